// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the encodings used by the line arbiter.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package lc3b_types;

  // Architectural word (line address) and cache line payload.
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  // Arbiter FSM states. RELEASE is a one-cycle dead slot after each
  // response so the finished requester has time to drop its strobe.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Which L1 a grant belongs to.
  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

  localparam int LC3B_WORD_W = $bits(lc3b_word);
  localparam int LC3B_DATA_W = $bits(lc3b_data);

  // The side that loses the next tie is the one granted most recently.
  function automatic arb_side_t other_side(input arb_side_t s);
    return (s == SIDE_I) ? SIDE_D : SIDE_I;
  endfunction

endpackage

// File: rtl/cache_line_arbiter_rr_select.sv
// Two-way round-robin pick between the I-side and D-side line requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a pick is consumed.
//
// Ports:
//   want_i, want_d : requester has read or write asserted
//   last_grant     : side that completed the most recent transaction
//   grant_valid    : at least one side wants memory
//   grant_side     : chosen side (meaningful only when grant_valid)
import lc3b_types::*;

module arb_rr_select (
  input  logic      want_i,
  input  logic      want_d,
  input  arb_side_t last_grant,
  output logic      grant_valid,
  output arb_side_t grant_side
);

  always_comb begin
    grant_valid = want_i | want_d;
    grant_side  = SIDE_I;
    if (want_i && want_d) begin
      // Tie: hand the memory to whoever did not go last.
      grant_side = other_side(last_grant);
    end else if (want_d) begin
      grant_side = SIDE_D;
    end else begin
      grant_side = SIDE_I;
    end
  end

endmodule

// File: rtl/cache_line_arbiter.sv
// Shares one physical-memory line port between the I-side and D-side L1 caches.
// Latency: request seen in IDLE reaches memory next cycle; resp/rdata return combinationally.
// Backpressure: loser waits until winner's pmem_resp, then RELEASE + IDLE (2-cycle gap).
//
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   i_pmem_* (address/read/write/wdata in, rdata/resp out) : I-side L1 miss port
//   d_pmem_* (address/read/write/wdata in, rdata/resp out) : D-side L1 miss port
//   pmem_*   (address/read/write/wdata out, rdata/resp in) : physical memory port
import lc3b_types::*;

module cache_line_arbiter #(
  parameter int ADDR_W = LC3B_WORD_W,
  parameter int LINE_W = LC3B_DATA_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q, state_d;
  arb_side_t  last_grant_q, last_grant_d;

  logic       want_i, want_d;
  logic       pick_vld;
  arb_side_t  pick_side;

  assign want_i = i_pmem_read | i_pmem_write;
  assign want_d = d_pmem_read | d_pmem_write;

  arb_rr_select u_rr_select (
    .want_i      (want_i),
    .want_d      (want_d),
    .last_grant  (last_grant_q),
    .grant_valid (pick_vld),
    .grant_side  (pick_side)
  );

  // Reset leaves last_grant at I so a simultaneous first request goes to D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SIDE_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state and all outputs. Outputs depend only on the registered state
  // plus the granted side's inputs, so the unselected side never leaks onto
  // memory and never sees the other side's read data.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;

    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    i_pmem_rdata = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // pmem_resp here is stray and deliberately not looked at.
        if (pick_vld) begin
          state_d = (pick_side == SIDE_D) ? GRANT_D : GRANT_I;
        end
      end

      GRANT_I: begin
        pmem_address = i_pmem_address;
        pmem_read    = i_pmem_read;
        pmem_write   = i_pmem_write;
        pmem_wdata   = i_pmem_wdata;
        i_pmem_rdata = pmem_rdata;
        // The grant is held until memory answers even if I drops its strobe.
        if (pmem_resp) begin
          i_pmem_resp  = 1'b1;
          last_grant_d = SIDE_I;
          state_d      = RELEASE;
        end
      end

      GRANT_D: begin
        pmem_address = d_pmem_address;
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_rdata = pmem_rdata;
        if (pmem_resp) begin
          d_pmem_resp  = 1'b1;
          last_grant_d = SIDE_D;
          state_d      = RELEASE;
        end
      end

      RELEASE: begin
        // Requester is still holding the just-answered strobe this cycle;
        // sitting out one cycle keeps it from being granted a second time.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A side may issue a read or a write-back, never both at once.
  a_i_rw_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(i_pmem_read && i_pmem_write)
  );

  a_d_rw_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write)
  );

endmodule

// File: tb/tb_cache_line_arbiter.sv
module tb_cache_line_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_pmem_address;
  logic              i_pmem_read;
  logic              i_pmem_write;
  logic [LINE_W-1:0] i_pmem_wdata;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic [ADDR_W-1:0] d_pmem_address;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic [ADDR_W-1:0] pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks   = 0;
  int failures = 0;

  // Per-test response pulse counters, sampled mid-cycle.
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;

  localparam logic [LINE_W-1:0] LINE_A5  = {16{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_WB  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [LINE_W-1:0] LINE_D1  = {16{8'h3C}};
  localparam logic [LINE_W-1:0] LINE_I1  = {16{8'h5A}};
  localparam logic [LINE_W-1:0] LINE_BAD = {16{8'hEE}};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i_pmem_resp) i_resp_cnt++;
    if (d_pmem_resp) d_resp_cnt++;
  end

  cache_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_write   (i_pmem_write),
    .i_pmem_wdata   (i_pmem_wdata),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_address   (pmem_address),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_pmem_address = '0; i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_wdata = '0;
    d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // ---------------- reset values ----------------
    // Drive live-looking inputs to prove reset forces every output to 0.
    i_pmem_read = 1'b1; i_pmem_address = 16'h7777; pmem_rdata = LINE_BAD; pmem_resp = 1'b1;
    tick(); tick(); settle();
    chk("rst_pmem_read",    {127'd0, pmem_read},    '0);
    chk("rst_pmem_write",   {127'd0, pmem_write},   '0);
    chk("rst_pmem_address", {112'd0, pmem_address}, '0);
    chk("rst_pmem_wdata",   pmem_wdata,             '0);
    chk("rst_i_resp",       {127'd0, i_pmem_resp},  '0);
    chk("rst_d_resp",       {127'd0, d_pmem_resp},  '0);
    chk("rst_i_rdata",      i_pmem_rdata,           '0);
    chk("rst_d_rdata",      d_pmem_rdata,           '0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // ---------------- T1: lone I read, 3-cycle memory ----------------
    i_resp_cnt = 0; d_resp_cnt = 0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
    settle();
    chk("t1_idle_no_read", {127'd0, pmem_read}, '0);
    tick(); settle();
    chk("t1_read_n1",  {127'd0, pmem_read},    128'd1);
    chk("t1_addr_n1",  {112'd0, pmem_address}, 128'h1230);
    tick();
    tick();
    pmem_rdata = LINE_A5; pmem_resp = 1'b1;
    settle();
    chk("t1_i_resp",  {127'd0, i_pmem_resp}, 128'd1);
    chk("t1_i_rdata", i_pmem_rdata,          LINE_A5);
    chk("t1_d_rdata_isolated", d_pmem_rdata, '0);
    tick();
    // RELEASE: requester still high, memory keeps driving data.
    settle();
    chk("t1_rel_read",  {127'd0, pmem_read},   '0);
    chk("t1_rel_iresp", {127'd0, i_pmem_resp}, '0);
    chk("t1_rel_rdata", i_pmem_rdata,          '0);
    clear_inputs();
    tick(); tick();
    chk("t1_i_pulses", 128'(i_resp_cnt), 128'd1);
    chk("t1_d_pulses", 128'(d_resp_cnt), 128'd0);

    // ---------------- T2: D write-back ----------------
    i_resp_cnt = 0; d_resp_cnt = 0;
    d_pmem_write = 1'b1; d_pmem_address = 16'h4440; d_pmem_wdata = LINE_WB;
    tick(); settle();
    chk("t2_write", {127'd0, pmem_write},   128'd1);
    chk("t2_read",  {127'd0, pmem_read},    '0);
    chk("t2_addr",  {112'd0, pmem_address}, 128'h4440);
    chk("t2_wdata", pmem_wdata,             LINE_WB);
    tick();
    pmem_resp = 1'b1;
    settle();
    chk("t2_d_resp", {127'd0, d_pmem_resp}, 128'd1);
    chk("t2_i_resp", {127'd0, i_pmem_resp}, '0);
    tick();
    clear_inputs();
    tick(); tick();
    chk("t2_d_pulses", 128'(d_resp_cnt), 128'd1);
    chk("t2_i_pulses", 128'(i_resp_cnt), 128'd0);

    // ---------------- T3: tie after reset, then alternation ----------------
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 16'h1000;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    tick(); settle();
    chk("t3_first_is_d", {112'd0, pmem_address}, 128'h2000);
    pmem_rdata = LINE_D1; pmem_resp = 1'b1;
    settle();
    chk("t3_d_resp",     {127'd0, d_pmem_resp}, 128'd1);
    chk("t3_i_no_resp",  {127'd0, i_pmem_resp}, '0);
    chk("t3_i_no_rdata", i_pmem_rdata,          '0);
    tick();                                   // RELEASE
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    settle();
    chk("t3_rel_read", {127'd0, pmem_read}, '0);
    tick(); settle();                         // IDLE
    chk("t3_idle_read", {127'd0, pmem_read}, '0);
    tick(); settle();                         // GRANT_I
    chk("t3_second_is_i", {112'd0, pmem_address}, 128'h1000);
    chk("t3_second_read", {127'd0, pmem_read},    128'd1);
    pmem_rdata = LINE_I1; pmem_resp = 1'b1;
    settle();
    chk("t3_i_rdata", i_pmem_rdata, LINE_I1);
    tick();                                   // RELEASE; both request again
    pmem_resp = 1'b0;
    d_pmem_read = 1'b1;
    tick(); tick(); settle();                 // IDLE -> GRANT
    chk("t3_third_is_d", {112'd0, pmem_address}, 128'h2000);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    tick(); tick(); settle();
    chk("t3_fourth_is_i", {112'd0, pmem_address}, 128'h1000);
    pmem_resp = 1'b1;
    tick();
    clear_inputs();
    tick();

    // ---------------- T4: D arrives while I is mid-transaction ----------------
    i_pmem_read = 1'b1; i_pmem_address = 16'h1000;
    tick();                                   // GRANT_I
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    settle();
    chk("t4_hold_addr_a", {112'd0, pmem_address}, 128'h1000);
    tick(); settle();
    chk("t4_hold_addr_b", {112'd0, pmem_address}, 128'h1000);
    chk("t4_d_waits",     {127'd0, d_pmem_resp},  '0);
    pmem_resp = 1'b1;
    settle();
    chk("t4_i_resp", {127'd0, i_pmem_resp}, 128'd1);
    tick();                                   // RELEASE
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    settle();
    chk("t4_gap1", {127'd0, pmem_read}, '0);
    tick(); settle();                         // IDLE
    chk("t4_gap2", {127'd0, pmem_read}, '0);
    tick(); settle();                         // GRANT_D
    chk("t4_d_granted", {112'd0, pmem_address}, 128'h2000);
    chk("t4_d_read",    {127'd0, pmem_read},    128'd1);
    pmem_resp = 1'b1;
    tick();
    clear_inputs();
    tick();

    // ---------------- T5: reset while D is waiting on memory ----------------
    d_pmem_write = 1'b1; d_pmem_address = 16'h4440; d_pmem_wdata = LINE_WB;
    pmem_rdata = LINE_D1;
    tick(); tick();                           // GRANT_D, memory mid-latency
    settle();
    chk("t5_pre_write", {127'd0, pmem_write}, 128'd1);
    rst = 1'b1;
    settle();
    chk("t5_rst_write", {127'd0, pmem_write},   '0);
    chk("t5_rst_addr",  {112'd0, pmem_address}, '0);
    chk("t5_rst_wdata", pmem_wdata,             '0);
    chk("t5_rst_rdata", d_pmem_rdata,           '0);
    tick();
    clear_inputs();
    rst = 1'b0;
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 16'h0BEE;
    tick(); settle();
    chk("t5_i_after_rst", {112'd0, pmem_address}, 128'h0BEE);
    pmem_resp = 1'b1;
    settle();
    chk("t5_i_resp", {127'd0, i_pmem_resp}, 128'd1);
    tick();
    clear_inputs();
    tick();

    // ---------------- T6: stray pmem_resp in IDLE ----------------
    i_resp_cnt = 0; d_resp_cnt = 0;
    pmem_resp = 1'b1; pmem_rdata = LINE_BAD;
    settle();
    chk("t6_i_resp",  {127'd0, i_pmem_resp}, '0);
    chk("t6_d_resp",  {127'd0, d_pmem_resp}, '0);
    chk("t6_i_rdata", i_pmem_rdata,          '0);
    tick(); tick();
    pmem_resp = 1'b0;
    // Still IDLE: a lone request is picked up the very next cycle.
    i_pmem_read = 1'b1; i_pmem_address = 16'h0042;
    tick(); settle();
    chk("t6_still_idle_grant", {112'd0, pmem_address}, 128'h0042);
    chk("t6_pulses", 128'(i_resp_cnt + d_resp_cnt), 128'd0);
    pmem_resp = 1'b1;
    tick();
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
